// File: rtl/if_stage_fq.sv
// if_stage_fq: LoongArch fetch stage with outstanding inst-SRAM request
// tracking and a fetch queue that decouples SRAM latency from ID stalls.
module if_stage_fq #(
    parameter logic [31:0] PC_RESET        = 32'h1c000000,
    parameter int          FQ_DEPTH        = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ds_allowin,
    output logic                       fs_to_ds_valid,
    output logic [31:0]                fs_to_ds_pc,
    output logic [31:0]                fs_to_ds_inst,
    output logic                       fs_to_ds_ex,
    output logic [5:0]                 fs_to_ds_ecode,
    output logic                       fs_to_ds_esubcode,
    input  logic                       ex_flush,
    input  logic [31:0]                ex_target,
    input  logic                       br_taken,
    input  logic [31:0]                br_target,
    input  logic                       br_stall,
    output logic                       inst_sram_req,
    output logic                       inst_sram_wr,
    output logic [1:0]                 inst_sram_size,
    output logic [3:0]                 inst_sram_wstrb,
    output logic [31:0]                inst_sram_addr,
    output logic [31:0]                inst_sram_wdata,
    input  logic                       inst_sram_addr_ok,
    input  logic                       inst_sram_data_ok,
    input  logic [31:0]                inst_sram_rdata,
    output logic [$clog2(FQ_DEPTH):0]  fq_count
);

    localparam int QW = $clog2(FQ_DEPTH);
    localparam int CW = QW + 1;
    localparam int IW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [5:0]  ECODE_ADE     = 6'h08;
    localparam logic        ESUBCODE_ADEF = 1'b0;
    localparam logic [31:0] ADEF_INST     = 32'h00100000;

    logic [31:0]         r_fetch_pc;
    logic [IW-1:0]       r_inflight;
    logic [IW-1:0]       r_discard;
    logic                r_halted;

    logic [31:0]         r_fq_pc   [FQ_DEPTH];
    logic [31:0]         r_fq_inst [FQ_DEPTH];
    logic [FQ_DEPTH-1:0] r_fq_ex;
    logic [QW-1:0]       r_wp;
    logic [QW-1:0]       r_rp;
    logic [CW-1:0]       r_count;

    logic [31:0]         r_pf_pc [MAX_OUTSTANDING];
    logic [PW-1:0]       r_pf_wp;
    logic [PW-1:0]       r_pf_rp;

    logic                w_redirect;
    logic [31:0]         w_target;
    logic                w_aligned;
    logic [IW-1:0]       w_live;
    logic                w_credit_ok;
    logic                w_inflight_ok;
    logic                w_req;
    logic                w_accept;
    logic                w_discard_nz;
    logic                w_push_data;
    logic                w_adef;
    logic                w_push;
    logic [31:0]         w_push_pc;
    logic [31:0]         w_push_inst;
    logic                w_valid;
    logic                w_pop;
    logic                w_head_ex;
    logic [IW-1:0]       w_inflight_nxt;
    logic [IW-1:0]       w_discard_nxt;

    function automatic logic [PW-1:0] pf_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_redirect    = ex_flush | br_taken;
    assign w_target      = ex_flush ? ex_target : br_target;
    assign w_aligned     = (r_fetch_pc[1:0] == 2'b00);
    assign w_live        = r_inflight - r_discard;
    // Every live request owns a queue slot, so a return can always be stored.
    assign w_credit_ok   = (32'(r_count) + 32'(w_live)) < 32'(FQ_DEPTH);
    assign w_inflight_ok = 32'(r_inflight) < 32'(MAX_OUTSTANDING);

    assign w_req = ~reset & ~r_halted & ~br_stall & ~w_redirect
                 & w_aligned & w_inflight_ok & w_credit_ok;
    assign w_accept = w_req & inst_sram_addr_ok;

    assign w_discard_nz = (r_discard != '0);
    assign w_push_data  = inst_sram_data_ok & ~w_discard_nz & ~w_redirect;
    assign w_adef = ~reset & ~r_halted & ~w_redirect & ~w_aligned
                  & (w_live == '0) & (32'(r_count) < 32'(FQ_DEPTH));
    assign w_push      = w_push_data | w_adef;
    assign w_push_pc   = w_adef ? r_fetch_pc : r_pf_pc[r_pf_rp];
    assign w_push_inst = w_adef ? ADEF_INST : inst_sram_rdata;

    assign w_valid = (r_count != '0) & ~w_redirect;
    assign w_pop   = w_valid & ds_allowin;

    assign w_inflight_nxt = r_inflight + IW'(w_accept)
                          - IW'(inst_sram_data_ok);
    // On redirect everything still outstanding becomes stale.
    assign w_discard_nxt = w_redirect ? w_inflight_nxt
                         : r_discard - IW'(inst_sram_data_ok & w_discard_nz);

    // Fetch PC, outstanding/discard counters and ADEF halt
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= PC_RESET;
            r_inflight <= '0;
            r_discard  <= '0;
            r_halted   <= 1'b0;
        end else begin
            r_inflight <= w_inflight_nxt;
            r_discard  <= w_discard_nxt;
            if (w_redirect) begin
                r_fetch_pc <= w_target;
                r_halted   <= 1'b0;
            end else begin
                if (w_accept) r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_adef)   r_halted   <= 1'b1;
            end
        end
    end

    // Fetch queue pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset || w_redirect) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + QW'(1);
            if (w_pop)  r_rp <= r_rp + QW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Fetch queue storage
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fq_pc[r_wp]   <= w_push_pc;
            r_fq_inst[r_wp] <= w_push_inst;
            r_fq_ex[r_wp]   <= w_adef;
        end
    end

    // PC FIFO pointers: one entry per live request, in issue order
    always_ff @(posedge clk) begin
        if (reset || w_redirect) begin
            r_pf_wp <= '0;
            r_pf_rp <= '0;
        end else begin
            if (w_accept)    r_pf_wp <= pf_inc(r_pf_wp);
            if (w_push_data) r_pf_rp <= pf_inc(r_pf_rp);
        end
    end

    // PC FIFO storage, written at accept time
    always_ff @(posedge clk) begin
        if (w_accept) r_pf_pc[r_pf_wp] <= r_fetch_pc;
    end

    // A response with nothing outstanding means SRAM and stage disagree
    always_ff @(posedge clk) begin
        if (!reset) assert (!(inst_sram_data_ok && r_inflight == '0));
    end

    assign w_head_ex = r_fq_ex[r_rp];

    assign fs_to_ds_valid    = w_valid;
    assign fs_to_ds_pc       = w_valid ? r_fq_pc[r_rp]   : 32'd0;
    assign fs_to_ds_inst     = w_valid ? r_fq_inst[r_rp] : 32'd0;
    assign fs_to_ds_ex       = w_valid & w_head_ex;
    assign fs_to_ds_ecode    = (w_valid & w_head_ex) ? ECODE_ADE : 6'd0;
    assign fs_to_ds_esubcode = (w_valid & w_head_ex) ? ESUBCODE_ADEF : 1'b0;

    assign inst_sram_req   = w_req;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'd2;
    assign inst_sram_wstrb = 4'd0;
    assign inst_sram_addr  = r_fetch_pc;
    assign inst_sram_wdata = 32'd0;

    assign fq_count = r_count;

endmodule
